// File: rtl/ss_downsizer_if.sv
// ss_downsizer_if: stream bundle carrying valid/ready/data/keep/last/user.
//   BYTES     - data width in bytes
//   USER_BITS - sideband width
// Modports:
//   master - drives valid, data, keep, last, user; receives ready
//   slave  - receives valid, data, keep, last, user; drives ready
interface ss_downsizer_if #(
   parameter int unsigned BYTES     = 8,
   parameter int unsigned USER_BITS = 2
);
   logic                 valid;
   logic                 ready;
   logic [8*BYTES-1:0]   data;
   logic [BYTES-1:0]     keep;
   logic                 last;
   logic [USER_BITS-1:0] user;

   modport master (output valid, data, keep, last, user, input ready);
   modport slave  (input valid, data, keep, last, user, output ready);
endinterface

// File: rtl/ss_downsizer.sv
// ss_downsizer: stream width converter. Each wide input beat is split into RATIO
// narrower output beats, least-significant sub-word first. On the last beat of a
// packet, trailing sub-words with no keep bits set are dropped.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   s_if - wide input stream (slave side, IN_BYTES wide)
//   m_if - narrow output stream (master side, IN_BYTES/RATIO wide)
module ss_downsizer #(
   parameter int unsigned IN_BYTES  = 8,
   parameter int unsigned RATIO     = 4,
   parameter int unsigned USER_BITS = 2
) (
   input  logic           clk,
   input  logic           rst,
   ss_downsizer_if.slave  s_if,
   ss_downsizer_if.master m_if
);
   localparam int unsigned OUT_BYTES = IN_BYTES / RATIO;
   localparam int unsigned IDX_W     = $clog2(RATIO);

   typedef enum logic [0:0] {StEmpty, StSend} state_e;

   state_e                            r_state;
   logic [RATIO-1:0][8*OUT_BYTES-1:0] r_data;
   logic [RATIO-1:0][OUT_BYTES-1:0]   r_keep;
   logic                              r_last;
   logic [USER_BITS-1:0]              r_user;
   logic [IDX_W-1:0]                  r_idx;
   logic [IDX_W-1:0]                  r_final_idx;

   logic w_send;
   logic w_at_final;
   logic w_take_out;
   logic w_take_in;

   // Last beat: highest sub-word with any keep bit (0 if none). Otherwise all sub-words.
   function automatic logic [IDX_W-1:0] f_final_idx(input logic [IN_BYTES-1:0] keep,
                                                     input logic                last);
      logic [RATIO-1:0][OUT_BYTES-1:0] sub;
      logic [IDX_W-1:0]                idx;
      sub = keep;
      idx = IDX_W'(RATIO - 1);
      if (last) begin
         idx = '0;
         for (int i = 0; i < RATIO; i++) begin
            if (|sub[i]) idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   assign w_send     = (r_state == StSend);
   assign w_at_final = (r_idx == r_final_idx);
   assign w_take_out = w_send && m_if.ready;
   // Accept a new beat when empty, or in the cycle the final sub-beat leaves.
   assign s_if.ready = !w_send || (m_if.ready && w_at_final);
   assign w_take_in  = s_if.valid && s_if.ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StEmpty;
         r_data      <= '0;
         r_keep      <= '0;
         r_last      <= 1'b0;
         r_user      <= '0;
         r_idx       <= '0;
         r_final_idx <= '0;
      end else if (w_take_in) begin
         r_data      <= s_if.data;
         r_keep      <= s_if.keep;
         r_last      <= s_if.last;
         r_user      <= s_if.user;
         r_idx       <= '0;
         r_final_idx <= f_final_idx(s_if.keep, s_if.last);
         r_state     <= StSend;
      end else if (w_take_out) begin
         if (!w_at_final) r_idx   <= r_idx + IDX_W'(1);
         else             r_state <= StEmpty;
      end
   end

   // Outputs are selected from registered state only; nothing from s_if reaches m_if.
   assign m_if.valid = w_send;
   assign m_if.data  = r_data[r_idx];
   assign m_if.keep  = r_keep[r_idx];
   assign m_if.last  = w_send && r_last && w_at_final;
   assign m_if.user  = r_user;
endmodule

// File: tb/tb_ss_downsizer.sv
// tb_ss_downsizer: directed self-checking bench for ss_downsizer (8 -> 2 bytes).
module tb_ss_downsizer;
   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  k;
      logic        l;
      logic [1:0]  u;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   ss_downsizer_if #(.BYTES(8), .USER_BITS(2)) s_if ();
   ss_downsizer_if #(.BYTES(2), .USER_BITS(2)) m_if ();

   ss_downsizer #(.IN_BYTES(8), .RATIO(4), .USER_BITS(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .s_if (s_if),
      .m_if (m_if)
   );

   always #5 clk = ~clk;

   logic [15:0] exp2 [4] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};
   logic [7:0]  bbk  [3] = '{8'hFF, 8'h30, 8'hFF};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic expect_beat(input string tag, input sb_t e);
      chk({tag, "_valid"}, m_if.valid, 1'b1);
      chk({tag, "_data"},  m_if.data,  e.d);
      chk({tag, "_keep"},  m_if.keep,  e.k);
      chk({tag, "_last"},  m_if.last,  e.l);
      chk({tag, "_user"},  m_if.user,  e.u);
   endtask

   function automatic logic [15:0] bb(input int j, input int k);
      return {4'(4'hA + j), 4'(k), 4'(4'hA + j), 4'(k)};
   endfunction

   task automatic set_bb_beat(input int j);
      s_if.valid = 1'b1;
      s_if.data  = {bb(j, 3), bb(j, 2), bb(j, 1), bb(j, 0)};
      s_if.keep  = bbk[j];
      s_if.last  = 1'b0;
      s_if.user  = 2'(j);
   endtask

   initial begin
      sb_t         q [$];
      sb_t         e;
      sb_t         held;
      logic        prev_stall;
      logic        acc;
      int          sent;
      int          cyc;
      int          fin;
      logic [7:0]  kk;

      // Reset with s_valid asserted: nothing captured.
      s_if.valid = 1'b1;
      s_if.data  = 64'h0123456789ABCDEF;
      s_if.keep  = 8'hFF;
      s_if.last  = 1'b1;
      s_if.user  = 2'd3;
      m_if.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_mvalid", m_if.valid, 1'b0);
         chk("rst_sready", s_if.ready, 1'b1);
      end
      chk("rst_mdata", m_if.data, 16'h0);
      chk("rst_mkeep", m_if.keep, 2'h0);
      chk("rst_mlast", m_if.last, 1'b0);
      chk("rst_muser", m_if.user, 2'h0);
      @(posedge clk); #1;
      s_if.valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_mvalid", m_if.valid, 1'b0);

      // Single full last beat.
      @(posedge clk); #1;
      s_if.valid = 1'b1;
      s_if.data  = 64'h8877665544332211;
      s_if.keep  = 8'hFF;
      s_if.last  = 1'b1;
      s_if.user  = 2'd2;
      @(negedge clk);
      chk("full_pre_mvalid", m_if.valid, 1'b0);
      chk("full_pre_sready", s_if.ready, 1'b1);
      @(posedge clk); #1;
      s_if.valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         expect_beat("full", '{d: exp2[k], k: 2'h3, l: (k == 3), u: 2'd2});
         chk("full_sready", s_if.ready, (k == 3));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("full_idle", m_if.valid, 1'b0);

      // Trailing trim: keep 0x07 -> two sub-beats.
      @(posedge clk); #1;
      s_if.valid = 1'b1;
      s_if.keep  = 8'h07;
      s_if.user  = 2'd1;
      @(posedge clk); #1;
      s_if.valid = 1'b0;
      @(negedge clk);
      expect_beat("trim0", '{d: 16'h2211, k: 2'h3, l: 1'b0, u: 2'd1});
      @(posedge clk); #1;
      @(negedge clk);
      expect_beat("trim1", '{d: 16'h4433, k: 2'h1, l: 1'b1, u: 2'd1});
      @(posedge clk); #1;
      @(negedge clk);
      chk("trim_idle", m_if.valid, 1'b0);

      // Zero-keep last beat -> one empty terminating beat.
      @(posedge clk); #1;
      s_if.valid = 1'b1;
      s_if.keep  = 8'h00;
      s_if.user  = 2'd3;
      @(posedge clk); #1;
      s_if.valid = 1'b0;
      @(negedge clk);
      expect_beat("zero", '{d: 16'h2211, k: 2'h0, l: 1'b1, u: 2'd3});
      chk("zero_sready", s_if.ready, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_idle", m_if.valid, 1'b0);

      // Back-to-back non-last beats: 12 output cycles with no bubble.
      @(posedge clk); #1;
      set_bb_beat(0);
      @(posedge clk); #1;
      set_bb_beat(1);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         expect_beat("bb", '{d: bb(c / 4, c % 4), k: bbk[c / 4][2 * (c % 4) +: 2], l: 1'b0,
                             u: 2'(c / 4)});
         chk("bb_sready", s_if.ready, ((c % 4) == 3));
         @(posedge clk); #1;
         if (c == 3) set_bb_beat(2);
         else if (c == 7) s_if.valid = 1'b0;
      end
      @(negedge clk);
      chk("bb_idle", m_if.valid, 1'b0);

      // Backpressure with random traffic against a sub-word model.
      sent       = 0;
      cyc        = 0;
      acc        = 1'b0;
      prev_stall = 1'b0;
      held       = '0;
      while ((sent < 200 || q.size() != 0) && cyc < 6000) begin
         @(posedge clk); #1;
         cyc++;
         if (!s_if.valid || acc) begin
            if (sent < 200 && $urandom_range(0, 3) != 0) begin
               s_if.valid = 1'b1;
               s_if.data  = {$urandom(), $urandom()};
               s_if.keep  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
               s_if.last  = ($urandom_range(0, 2) == 0);
               s_if.user  = 2'($urandom());
            end else begin
               s_if.valid = 1'b0;
            end
         end
         m_if.ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (prev_stall) begin
            chk("hold_valid", m_if.valid, 1'b1);
            chk("hold_beat", {m_if.data, m_if.keep, m_if.last, m_if.user}, held);
         end
         acc = s_if.valid && s_if.ready;
         if (acc) begin
            kk  = s_if.keep;
            fin = 3;
            if (s_if.last) begin
               fin = 0;
               for (int i = 0; i < 4; i++) if (kk[2 * i +: 2] != 2'b00) fin = i;
            end
            for (int i = 0; i <= fin; i++)
               q.push_back('{d: s_if.data[16 * i +: 16], k: kk[2 * i +: 2],
                             l: s_if.last && (i == fin), u: s_if.user});
            sent++;
         end
         if (m_if.valid && m_if.ready) begin
            if (q.size() == 0) begin
               chk("bp_unexpected_beat", 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               expect_beat("bp", e);
            end
         end
         prev_stall = m_if.valid && !m_if.ready;
         held       = {m_if.data, m_if.keep, m_if.last, m_if.user};
      end
      chk("bp_in_time", (cyc < 6000), 1'b1);
      chk("bp_drained", q.size(), 0);

      // Asynchronous reset mid-packet.
      @(posedge clk); #1;
      s_if.valid = 1'b1;
      s_if.keep  = 8'hFF;
      s_if.last  = 1'b0;
      m_if.ready = 1'b0;
      @(posedge clk); #1;
      s_if.valid = 1'b0;
      @(negedge clk);
      chk("arst_pre_mvalid", m_if.valid, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk("arst_mvalid", m_if.valid, 1'b0);
      chk("arst_sready", s_if.ready, 1'b1);
      chk("arst_mkeep", m_if.keep, 2'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("arst_idle", m_if.valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ss_downsizer.md
Name: ss_downsizer

Overview:
- Stream width converter. Splits each wide input beat into RATIO narrower output beats, least-significant sub-word first.
- Sits directly upstream of ss_reg_slice. Its master side drives the slice's input stream, typically on a narrower link after a wide datapath.
- Uses the standard stream signal set: valid, ready, data, keep, last, user.
- Sustains full throughput on the output: one output beat per cycle while the downstream is ready.

Parameters:
- IN_BYTES, 8, input data width in bytes.
- RATIO, 4, output beats per input beat. Must be a power of 2 ≥ 2 and must divide IN_BYTES. OUT_BYTES = IN_BYTES/RATIO.
- USER_BITS, 2, sideband width. Passed through unchanged.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset. Asserted when 0. Deassertion must be synchronous to clk externally.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  8*IN_BYTES  input data.
- s_keep  in  IN_BYTES  input byte enables.
- s_last  in  1  end of packet.
- s_user  in  USER_BITS  input sideband.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  8*OUT_BYTES  output sub-word.
- m_keep  out  OUT_BYTES  output byte enables.
- m_last  out  1  end of packet on output.
- m_user  out  USER_BITS  copy of the buffered s_user.

Behaviour:
- Reset (rst=0, asynchronous): m_valid=0, m_last=0, m_data=0, m_keep=0, m_user=0, s_ready=1, state=EMPTY, idx=0.
- Storage: one wide holding register (data, keep, last, user) plus sub-word index idx of width log2(RATIO).
- State EMPTY: s_ready=1, m_valid=0.
  - On s_valid: capture the beat, set idx=0, compute final_idx, go to SEND.
- State SEND: m_valid=1.
  - m_data = held data byte slice [idx*OUT_BYTES +: OUT_BYTES]; m_keep uses the same slice of held keep.
  - m_user = held user on every sub-beat.
- final_idx:
  - Non-last input beat: final_idx = RATIO-1. All sub-beats are emitted regardless of keep.
  - Last input beat: final_idx = index of the highest sub-word with any keep bit set. Trailing all-zero sub-words are dropped.
  - Last input beat with keep all zero: final_idx=0, so one beat with m_keep=0 and m_last=1 is emitted.
- m_last = held last && (idx == final_idx).
- On m_valid && m_ready with idx != final_idx: idx increments.
- On m_valid && m_ready with idx == final_idx:
  - If s_valid, capture the new beat in the same cycle, set idx=0 and stay in SEND (zero-bubble).
  - Otherwise go to EMPTY.
- s_ready = (state==EMPTY) || (m_ready && idx==final_idx). This combinational path from m_ready is intentional; the downstream ss_reg_slice breaks it.
- Latency: an input accepted at edge N presents its first output beat after edge N (registered output). No combinational path from s_* to m_*.
- Holding invariant: while m_valid=1 && m_ready=0, all m_* outputs hold stable.
- Input data is not inspected for keep in the middle of a packet. Sparse keep on non-last beats is forwarded as-is.
- Reset asserted mid-packet: the beat in flight is discarded. Outputs return to reset values immediately (asynchronously).

Test Plan:
- Reset check: hold rst=0 for 3 cycles with s_valid=1 -> m_valid=0, s_ready=1 throughout; no beat captured.
- Single full beat: s_data=0x8877665544332211, s_keep=0xFF, s_last=1, m_ready=1 -> four beats with m_data 0x2211, 0x4433, 0x6655, 0x8877, each m_keep=0x3; m_last=1 only on the fourth; s_ready=1 again in the cycle the fourth is taken.
- Trailing trim: last beat with s_keep=0x07 -> two beats: m_keep=0x3, then m_keep=0x1 with m_last=1. Sub-words 2–3 are not emitted.
- Zero-keep last beat: s_keep=0x00, s_last=1 -> exactly one beat with m_keep=0, m_last=1.
- Back-to-back with m_ready=1 and s_valid held high for 3 non-last beats -> 12 consecutive output cycles with no bubble; s_ready high exactly on cycles where idx=3.
- Backpressure: m_ready toggles pseudo-randomly over 200 beats with random keep/last -> output stream equals the golden model's sub-word split; m_* stable while m_valid && !m_ready; m_user matches the originating input beat.
